// File: rtl/game_timer.sv
// game_timer: round countdown with a 1 Hz tick, binary and BCD seconds-left, and a held expiry flag.
// Define GAME_TIMER_WARN_EN to add the registered time_warn output.
module game_timer #(
  parameter int CLK_HZ       = 100000000,
  parameter int GAME_SECONDS = 30,
  parameter int WARN_SECONDS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_active,
  input  logic       sys_reset,
  output logic       game_time_up,
  output logic       tick_1hz,
  output logic [6:0] time_left,
  output logic [7:0] time_left_bcd
`ifdef GAME_TIMER_WARN_EN
  ,
  output logic       time_warn
`endif
);

  localparam int            PW      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]    TL_INIT = 7'(GAME_SECONDS);

  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("game_timer: CLK_HZ must be >= 2");
  end
  if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_game_seconds
    $error("game_timer: GAME_SECONDS must be in 1..99");
  end
  if (WARN_SECONDS < 1 || WARN_SECONDS > GAME_SECONDS) begin : g_bad_warn_seconds
    $error("game_timer: WARN_SECONDS must be in 1..GAME_SECONDS");
  end

  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_nxt;
  logic [6:0]    time_left_nxt;
  logic          time_up_nxt;
  logic          tick_nxt;
  logic          advance;
  logic          wrap;

  // Counting freezes once expired, which is what keeps time_left from wrapping below zero.
  assign advance = game_active && !game_time_up;
  assign wrap    = (prescaler == PRE_MAX);

  always_comb begin
    prescaler_nxt = prescaler;
    time_left_nxt = time_left;
    time_up_nxt   = game_time_up;
    tick_nxt      = 1'b0;
    if (sys_reset) begin
      prescaler_nxt = '0;
      time_left_nxt = TL_INIT;
      time_up_nxt   = 1'b0;
    end else if (advance) begin
      if (wrap) begin
        prescaler_nxt = '0;
        if (time_left != 7'd0) begin
          time_left_nxt = time_left - 7'd1;
          tick_nxt      = 1'b1;
        end
        if (time_left <= 7'd1) begin
          time_up_nxt = 1'b1;
        end
      end else begin
        prescaler_nxt = prescaler + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler    <= '0;
      time_left    <= TL_INIT;
      game_time_up <= 1'b0;
      tick_1hz     <= 1'b0;
    end else begin
      prescaler    <= prescaler_nxt;
      time_left    <= time_left_nxt;
      game_time_up <= time_up_nxt;
      tick_1hz     <= tick_nxt;
    end
  end

`ifdef GAME_TIMER_WARN_EN
  localparam logic [6:0] WARN_MAX = 7'(WARN_SECONDS);

  // Built from the next-state values so the flag changes on the same edge as time_left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_warn <= 1'b0;
    end else begin
      time_warn <= !time_up_nxt && (time_left_nxt != 7'd0) && (time_left_nxt <= WARN_MAX);
    end
  end
`endif

  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;

  // Binary-to-BCD by comparison against multiples of ten; time_left never exceeds 99.
  always_comb begin
    bcd_tens = 4'd0;
    bcd_ones = time_left[3:0];
    for (int i = 1; i <= 9; i++) begin
      if (time_left >= 7'(10 * i)) begin
        bcd_tens = 4'(i);
        bcd_ones = 4'(time_left - 7'(10 * i));
      end
    end
  end

  assign time_left_bcd = {bcd_tens, bcd_ones};

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed and random checks of game_timer against an elapsed-cycle reference model.
// With GAME_TIMER_WARN_EN defined, a second 45-second instance checks time_warn and two-digit BCD.
module tb_game_timer;

  localparam int CLK_HZ = 10;
  localparam int GS0    = 3;
  localparam int WS0    = 2;
  localparam int GS1    = 45;
  localparam int WS1    = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       game_active;
  logic       sys_reset;
  logic       game_time_up;
  logic       tick_1hz;
  logic [6:0] time_left;
  logic [7:0] time_left_bcd;
`ifdef GAME_TIMER_WARN_EN
  logic       time_warn;
  logic       game_time_up_b;
  logic       tick_1hz_b;
  logic [6:0] time_left_b;
  logic [7:0] time_left_bcd_b;
  logic       time_warn_b;
`endif

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  int en_cnt0;
  int en_cnt1;
  int exp_tick0;
  int exp_tick1;

  always #5 clk = ~clk;

  game_timer #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS0), .WARN_SECONDS(WS0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .game_active  (game_active),
    .sys_reset    (sys_reset),
    .game_time_up (game_time_up),
    .tick_1hz     (tick_1hz),
    .time_left    (time_left),
    .time_left_bcd(time_left_bcd)
`ifdef GAME_TIMER_WARN_EN
    ,
    .time_warn    (time_warn)
`endif
  );

`ifdef GAME_TIMER_WARN_EN
  game_timer #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS1), .WARN_SECONDS(WS1)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .game_active  (game_active),
    .sys_reset    (sys_reset),
    .game_time_up (game_time_up_b),
    .tick_1hz     (tick_1hz_b),
    .time_left    (time_left_b),
    .time_left_bcd(time_left_bcd_b),
    .time_warn    (time_warn_b)
  );
`endif

  // Reference model: the round state is fully determined by enabled cycles since reload.
  function automatic int exp_left(int cnt, int gs);
    return gs - cnt / CLK_HZ;
  endfunction

  function automatic int exp_up(int cnt, int gs);
    return (cnt >= gs * CLK_HZ) ? 1 : 0;
  endfunction

  function automatic int exp_bcd(int left);
    return (left / 10) * 16 + (left % 10);
  endfunction

  function automatic int exp_warn(int cnt, int gs, int ws);
    int left;
    left = exp_left(cnt, gs);
    return (exp_up(cnt, gs) == 0 && left >= 1 && left <= ws) ? 1 : 0;
  endfunction

  task automatic model_clear();
    en_cnt0   = 0;
    en_cnt1   = 0;
    exp_tick0 = 0;
    exp_tick1 = 0;
  endtask

  task automatic model_edge();
    if (sys_reset) begin
      model_clear();
    end else begin
      exp_tick0 = 0;
      exp_tick1 = 0;
      if (game_active && en_cnt0 < GS0 * CLK_HZ) begin
        en_cnt0++;
        exp_tick0 = (en_cnt0 % CLK_HZ == 0) ? 1 : 0;
      end
      if (game_active && en_cnt1 < GS1 * CLK_HZ) begin
        en_cnt1++;
        exp_tick1 = (en_cnt1 % CLK_HZ == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    check_eq("time_left",    32'(time_left),     32'(exp_left(en_cnt0, GS0)));
    check_eq("time_left_bcd", 32'(time_left_bcd), 32'(exp_bcd(exp_left(en_cnt0, GS0))));
    check_eq("game_time_up", 32'(game_time_up),  32'(exp_up(en_cnt0, GS0)));
    check_eq("tick_1hz",     32'(tick_1hz),      32'(exp_tick0));
`ifdef GAME_TIMER_WARN_EN
    check_eq("time_warn",    32'(time_warn),     32'(exp_warn(en_cnt0, GS0, WS0)));
    check_eq("b_time_left",  32'(time_left_b),   32'(exp_left(en_cnt1, GS1)));
    check_eq("b_bcd",        32'(time_left_bcd_b), 32'(exp_bcd(exp_left(en_cnt1, GS1))));
    check_eq("b_time_up",    32'(game_time_up_b), 32'(exp_up(en_cnt1, GS1)));
    check_eq("b_tick",       32'(tick_1hz_b),    32'(exp_tick1));
    check_eq("b_time_warn",  32'(time_warn_b),   32'(exp_warn(en_cnt1, GS1, WS1)));
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
  task automatic applyStimulus(input logic ga, input logic sr, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      game_active = ga;
      sys_reset   = sr;
      @(posedge clk);
      model_edge();
      #1;
      if (tick_1hz === 1'b1) ticks++;
      checkOutput();
    end
  endtask

  initial begin
    logic ga;
    logic sr;

    reset_n     = 1'b0;
    game_active = 1'b0;
    sys_reset   = 1'b0;
    model_clear();
    #23;
    checkOutput();
    check_eq("reset_bcd", 32'(time_left_bcd), 32'h03);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] full round then hold");
    ticks = 0;
    applyStimulus(1'b1, 1'b0, 30);
    check_eq("round_ticks", 32'(ticks), 32'd3);
    check_eq("round_up", 32'(game_time_up), 32'd1);
    applyStimulus(1'b1, 1'b0, 20);
    check_eq("hold_left", 32'(time_left), 32'd0);
    check_eq("hold_ticks", 32'(ticks), 32'd3);

    $display("[TB] reload after expiry");
    applyStimulus(1'b0, 1'b1, 1);
    check_eq("reload_bcd", 32'(time_left_bcd), 32'h03);
    check_eq("reload_up", 32'(game_time_up), 32'd0);

    $display("[TB] pause and resume");
    applyStimulus(1'b1, 1'b0, 7);
    ticks = 0;
    applyStimulus(1'b0, 1'b0, 50);
    check_eq("pause_ticks", 32'(ticks), 32'd0);
    applyStimulus(1'b1, 1'b0, 2);
    check_eq("resume_2nd", 32'(time_left), 32'd3);
    applyStimulus(1'b1, 1'b0, 1);
    check_eq("resume_3rd", 32'(time_left), 32'd2);
    applyStimulus(1'b1, 1'b0, 22);
    check_eq("resumed_round_up", 32'(game_time_up), 32'd1);

    $display("[TB] sys_reset over game_active");
    ticks = 0;
    applyStimulus(1'b1, 1'b1, 25);
    check_eq("prio_left", 32'(time_left), 32'd3);
    check_eq("prio_ticks", 32'(ticks), 32'd0);

    $display("[TB] async reset mid-round");
    applyStimulus(1'b1, 1'b0, 13);
    check_eq("pre_reset_left", 32'(time_left), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    checkOutput();
    check_eq("async_left", 32'(time_left), 32'd3);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 9);
    check_eq("post_reset_9", 32'(time_left), 32'd3);
    applyStimulus(1'b1, 1'b0, 1);
    check_eq("post_reset_10", 32'(time_left), 32'd2);

    $display("[TB] random stimulus");
    for (int i = 0; i < 400; i++) begin
      ga = ($urandom_range(0, 3) != 0);
      sr = ($urandom_range(0, 59) == 0);
      applyStimulus(ga, sr, 1);
    end

`ifdef GAME_TIMER_WARN_EN
    $display("[TB] 45-second round with warning");
    applyStimulus(1'b0, 1'b1, 1);
    check_eq("b_start_bcd", 32'(time_left_bcd_b), 32'h45);
    applyStimulus(1'b1, 1'b0, 460);
    check_eq("b_end_warn", 32'(time_warn_b), 32'd0);
    check_eq("b_end_left", 32'(time_left_b), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, giving clock cycles per game second (legal range >= 2).
REQ-002 The block SHALL have parameter GAME_SECONDS, default 30, giving round length in seconds (legal range 1..99).
REQ-003 The block SHALL have parameter WARN_SECONDS, default 5, giving the warning threshold in seconds (legal range 1..GAME_SECONDS); it is used only under REQ-024.
REQ-004 Port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port game_active, input, 1 bit: from the game FSM; 1 means the round is running.
REQ-007 Port sys_reset, input, 1 bit: from the game FSM; 1 means reload the round (FSM idle state).
REQ-008 Port game_time_up, output, 1 bit: 1 means the round has expired; synchronous to clk and fed to the game FSM.
REQ-009 Port tick_1hz, output, 1 bit: one-cycle pulse on each second decrement.
REQ-010 Port time_left, output, 7 bits: seconds remaining, unsigned binary.
REQ-011 Port time_left_bcd, output, 8 bits: seconds remaining as BCD; [7:4] is tens and [3:0] is ones.

Function
REQ-012 The prescaler SHALL count 0..CLK_HZ-1 and advance only when game_active=1, sys_reset=0 and game_time_up=0.
REQ-013 When the prescaler is at CLK_HZ-1 and advancing, on the next edge it SHALL wrap to 0, time_left SHALL decrement by 1, and tick_1hz SHALL be 1 for exactly that one cycle.
REQ-014 The first decrement after a reload SHALL occur exactly CLK_HZ enabled cycles after enabling begins.
REQ-015 On the edge where time_left goes from 1 to 0, game_time_up SHALL become 1, coincident with the final tick_1hz.
REQ-016 game_time_up SHALL stay 1 (level) and time_left SHALL stay 0 until sys_reset=1 or reset_n=0; time_left SHALL never wrap below 0.
REQ-017 When sys_reset=1 on an edge: time_left SHALL be set to GAME_SECONDS, the prescaler to 0, game_time_up to 0 and tick_1hz to 0.
REQ-018 sys_reset SHALL have priority over game_active when both are 1.
REQ-019 When game_active=0 and sys_reset=0, the prescaler and time_left SHALL hold their values (pause, or show-score hold).
REQ-020 On resume after a pause, counting SHALL continue from the held prescaler value, with no extra or lost cycles.
REQ-021 time_left_bcd SHALL be derived combinationally from time_left: tens = time_left/10 and ones = time_left mod 10; it is always consistent with time_left in the same cycle.
REQ-022 Parameter values outside their legal ranges SHALL cause an elaboration-time error.

Reset
REQ-023 While reset_n=0, asynchronously and independent of clk:
- time_left = GAME_SECONDS, with time_left_bcd matching it
- prescaler = 0
- game_time_up = 0
- tick_1hz = 0
- time_warn = 0 (when present)
Normal operation SHALL resume on the first rising edge after reset_n=1.

Configuration
REQ-024 With macro GAME_TIMER_WARN_EN defined, the block SHALL add output port time_warn (1 bit).
- time_warn is registered and updates on the same edge as time_left.
- time_warn = 1 exactly when game_time_up=0 and 1 <= time_left <= WARN_SECONDS.
REQ-025 Without GAME_TIMER_WARN_EN, the time_warn port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-026 Bench parameters SHALL be CLK_HZ=10 and GAME_SECONDS=3 (WARN_SECONDS=2 when the macro is enabled). The bench SHALL cover:
- Reset then sys_reset=0, game_active=1 -> time_left 3->2->1->0 at cycles 10, 20 and 30; three tick_1hz pulses; game_time_up=1 at cycle 30 and held at 1 for 20 further cycles.
- game_active=1 for 7 cycles, then 0 for 50 cycles, then 1 -> first decrement on the 3rd enabled cycle after resume; no tick while paused.
- After expiry, sys_reset=1 for 1 cycle -> time_left=3, time_left_bcd=8'h03, game_time_up=0; a new round then counts normally.
- sys_reset=1 and game_active=1 together for 25 cycles -> time_left stays 3 and no tick_1hz.
- reset_n pulsed low mid-round at time_left=2 with a partial prescaler -> outputs return to reset values immediately, without a clock edge.
- GAME_SECONDS=45 with the macro on -> time_left_bcd=8'h45 at start; time_warn=1 only while time_left is 5..1; time_warn=0 at time_left=0.
